// File: rtl/acc_mem_readout.sv
// rtl/acc_mem_readout.sv - accumulator memory readout to a ready/valid stream, optional clear-after-read (ACC_READOUT_CLEAR_EN)
module acc_mem_readout #(
    parameter int WORD_WIDTH = 32,
    parameter int MEM_SIZE   = 553
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_readout,
    input  logic                  abort,
    input  logic [9:0]            rd_base_i,
    input  logic [9:0]            rd_len_i,
    output logic [9:0]            acc_mem_addr_o,
    input  logic [WORD_WIDTH-1:0] acc_mem_data_i,
    output logic                  acc_mem_write_en,
    output logic [WORD_WIDTH-1:0] acc_mem_write_data,
    output logic [WORD_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic                  readout_done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND,
`ifdef ACC_READOUT_CLEAR_EN
        CLEAR,
`endif
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [9:0]            addr_q, addr_d;
    logic [9:0]            remaining_q, remaining_d;
    logic [WORD_WIDTH-1:0] m_data_q, m_data_d;
    logic                  m_valid_q, m_valid_d;
    logic                  m_last_q, m_last_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  we_q, we_d;
    logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
    logic [9:0]            addr_inc;
    logic [9:0]            base_mod;

    // Next address wraps from MEM_SIZE-1 back to 0; out-of-range bases fold into the memory
    always_comb begin
        addr_inc = (32'(addr_q) + 32'd1 == MEM_SIZE) ? 10'd0 : addr_q + 10'd1;
        base_mod = 10'(32'(rd_base_i) % MEM_SIZE);
    end

    // Next-state and registered-output computation; abort overrides everything outside IDLE
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        we_d        = 1'b0;
        wdata_d     = '0;
        case (state_q)
            IDLE: begin
                if (start_readout) begin
                    busy_d = 1'b1;
                    if (rd_len_i != 10'd0) begin
                        addr_d      = base_mod;
                        remaining_d = rd_len_i;
                        state_d     = FETCH;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            FETCH: begin
                m_data_d  = acc_mem_data_i;
                m_valid_d = 1'b1;
                m_last_d  = (remaining_q == 10'd1);
                state_d   = SEND;
            end
            SEND: begin
                if (m_ready) begin
                    m_valid_d   = 1'b0;
                    m_last_d    = 1'b0;
                    remaining_d = remaining_q - 10'd1;
`ifdef ACC_READOUT_CLEAR_EN
                    we_d    = 1'b1;
                    state_d = CLEAR;
`else
                    addr_d  = addr_inc;
                    state_d = (remaining_q == 10'd1) ? DONE : FETCH;
`endif
                end
            end
`ifdef ACC_READOUT_CLEAR_EN
            CLEAR: begin
                addr_d  = addr_inc;
                state_d = (remaining_q == 10'd0) ? DONE : FETCH;
            end
`endif
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort && state_q != IDLE) begin
            state_d   = IDLE;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            we_d      = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b0;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
        end
    end

    assign acc_mem_addr_o     = addr_q;
    assign acc_mem_write_en   = we_q;
    assign acc_mem_write_data = wdata_q;
    assign m_data             = m_data_q;
    assign m_valid            = m_valid_q;
    assign m_last             = m_last_q;
    assign busy               = busy_q;
    assign readout_done       = done_q;

endmodule

// File: tb/tb_acc_mem_readout.sv
// tb/tb_acc_mem_readout.sv - directed scoreboard bench for acc_mem_readout
module tb_acc_mem_readout;
    localparam int W  = 32;
    localparam int MS = 553;

    logic          clk = 1'b0;
    logic          rst, start_readout, abort, m_ready;
    logic [9:0]    rd_base_i, rd_len_i;
    logic [9:0]    acc_mem_addr_o;
    logic [W-1:0]  acc_mem_data_i;
    logic          acc_mem_write_en;
    logic [W-1:0]  acc_mem_write_data;
    logic [W-1:0]  m_data;
    logic          m_valid, m_last, busy, readout_done;

    always #5 clk = ~clk;

    acc_mem_readout #(.WORD_WIDTH(W), .MEM_SIZE(MS)) dut (
        .clk(clk), .rst(rst), .start_readout(start_readout), .abort(abort),
        .rd_base_i(rd_base_i), .rd_len_i(rd_len_i),
        .acc_mem_addr_o(acc_mem_addr_o), .acc_mem_data_i(acc_mem_data_i),
        .acc_mem_write_en(acc_mem_write_en), .acc_mem_write_data(acc_mem_write_data),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .busy(busy), .readout_done(readout_done)
    );

    // accumulator memory: word k holds k after init, asynchronous read
    logic [W-1:0] mem [0:1023];
    logic         mem_init;
    assign acc_mem_data_i = mem[acc_mem_addr_o];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int k = 0; k < 1024; k++) mem[k] <= W'(k);
        end else if (acc_mem_write_en) begin
            mem[acc_mem_addr_o] <= acc_mem_write_data;
        end
    end

    typedef struct packed {
        logic         last;
        logic [W-1:0] data;
    } exp_t;

    exp_t         sb[$];
    int           wq[$];
    logic [W-1:0] exp_mem [0:MS-1];
    int           tests = 0;
    int           fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // stream scoreboard: compare every accepted word
    always @(negedge clk) begin
        exp_t e;
        if (!rst && m_valid && m_ready && !abort) begin
            if (sb.size() == 0) begin
                check("sb_pending", 64'(sb.size()), 64'd1);
            end else begin
                e = sb.pop_front();
                check("m_data", 64'(m_data), 64'(e.data));
                check("m_last", 64'(m_last), 64'(e.last));
            end
        end
    end

    // clear-write monitor: only expected writes of zero at the just-read address
    always @(negedge clk) begin
        if (!rst && acc_mem_write_en) begin
            check("wr_data", 64'(acc_mem_write_data), 64'd0);
            if (wq.size() == 0) check("wr_pending", 64'(wq.size()), 64'd1);
            else check("wr_addr", 64'(acc_mem_addr_o), 64'(wq.pop_front()));
        end
    end

    task automatic do_start(input int base, input int len);
        exp_t e;
        int   a;
        for (int i = 0; i < len; i++) begin
            a = ((base % MS) + i) % MS;
            e.last = (i == len - 1);
            e.data = exp_mem[a];
            sb.push_back(e);
`ifdef ACC_READOUT_CLEAR_EN
            exp_mem[a] = '0;
            wq.push_back(a);
`endif
        end
        rd_base_i     = 10'(base);
        rd_len_i      = 10'(len);
        start_readout = 1'b1;
        @(posedge clk); #1;
        start_readout = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!readout_done && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_done_seen"}, 64'(readout_done), 64'd1);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 64'(readout_done), 64'd0);
        check({tag, "_busy_low"}, 64'(busy), 64'd0);
        check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_addr"}, 64'(acc_mem_addr_o), 64'd0);
        check({tag, "_we"}, 64'(acc_mem_write_en), 64'd0);
        check({tag, "_wdata"}, 64'(acc_mem_write_data), 64'd0);
        check({tag, "_m_data"}, 64'(m_data), 64'd0);
        check({tag, "_m_valid"}, 64'(m_valid), 64'd0);
        check({tag, "_m_last"}, 64'(m_last), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(readout_done), 64'd0);
    endtask

    initial begin
        logic [W-1:0] hold_d;
        logic [9:0]   hold_a;
        logic         hit, saw_done, saw_valid;

        for (int k = 0; k < MS; k++) exp_mem[k] = W'(k);
        rst = 1'b1; mem_init = 1'b1; start_readout = 1'b0; abort = 1'b0;
        m_ready = 1'b1; rd_base_i = '0; rd_len_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b0; mem_init = 1'b0;
        @(posedge clk); #1;

        // base 0, len 4: latency, order, m_last, done pulse; start while busy ignored
        do_start(0, 4);
        check("lat_busy", 64'(busy), 64'd1);
        check("lat_valid_early", 64'(m_valid), 64'd0);
        @(posedge clk); #1;
        check("lat_valid", 64'(m_valid), 64'd1);
        rd_base_i = 10'd300; rd_len_i = 10'd5; start_readout = 1'b1;
        @(posedge clk); #1;
        start_readout = 1'b0;
        wait_done("seq4");

        // wrap past the top of memory, and an out-of-range base
        do_start(551, 3);
        wait_done("wrap");
        do_start(560, 2);
        wait_done("base_mod");

        // downstream stall on the first word
        m_ready = 1'b0;
        do_start(40, 2);
        @(posedge clk); #1;
        hold_d = m_data; hold_a = acc_mem_addr_o;
        check("stall_first", 64'(m_data), 64'd40);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("stall_valid", 64'(m_valid), 64'd1);
            check("stall_data", 64'(m_data), 64'(hold_d));
            check("stall_addr", 64'(acc_mem_addr_o), 64'(hold_a));
        end
        m_ready = 1'b1;
        wait_done("stall");

        // abort during the second word of an 8-word readout, m_ready also high
        do_start(100, 8);
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(posedge clk); #1;
            if (m_valid && m_data == W'(101)) hit = 1'b1;
        end
        check("abort_reach", 64'(hit), 64'd1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_valid", 64'(m_valid), 64'd0);
        check("abort_last", 64'(m_last), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_we", 64'(acc_mem_write_en), 64'd0);
        saw_done = readout_done;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            saw_done = saw_done | readout_done;
        end
        check("abort_no_done", 64'(saw_done), 64'd0);
        sb.delete(); wq.delete();
        do_start(200, 2);
        wait_done("after_abort");

        // zero length: no words, done pulse two edges after start driven
        do_start(5, 0);
        check("len0_busy", 64'(busy), 64'd1);
        saw_valid = m_valid;
        @(posedge clk); #1;
        saw_valid = saw_valid | m_valid;
        check("len0_done", 64'(readout_done), 64'd1);
        check("len0_no_valid", 64'(saw_valid), 64'd0);
        @(posedge clk); #1;
        check("len0_done_pulse", 64'(readout_done), 64'd0);
        check("len0_busy_low", 64'(busy), 64'd0);

        // clear-after-read, then read the same words back
        do_start(10, 2);
        wait_done("clear1");
        check("clear_writes_all", 64'(wq.size()), 64'd0);
        do_start(10, 2);
        wait_done("clear2");

        // reset in the middle of a transfer
        do_start(300, 5);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset("midrst");
        rst = 1'b0;
        sb.delete(); wq.delete();
        @(posedge clk); #1;
        do_start(400, 2);
        wait_done("after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
